bcd_serial_add_ctrl: RTL and testbench

//   Sequencer that adds two DIGITS-wide packed BCD operands using one shared

---
 rtl/bcd_serial_add_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
//
// Purpose
//   Adds two DIGITS-wide packed BCD operands using a single one-digit BCD
//   adder stage (digit + digit + carry). One digit is processed per clock,
//   least-significant digit first, and the decimal carry ripples between
//   steps. A requester starts an operation with a start pulse and collects
//   the result when done pulses.
//
//   Sequence: IDLE -> ADD (DIGITS cycles) -> DONE (1 cycle) -> IDLE.
//   The start-to-done latency is DIGITS+1 cycles and the earliest follow-up
//   start is accepted in the cycle after done.
//
// Parameters
//   DIGITS  number of BCD digits per operand (>= 1)
//
// Ports
//   clk    in   1          rising-edge clock
//   rst    in   1          synchronous, active-high reset
//   start  in   1          request; sampled only while idle
//   a      in   4*DIGITS   operand A, packed BCD, digit 0 = a[3:0]
//   b      in   4*DIGITS   operand B, packed BCD, digit 0 = b[3:0]
//   sum    out  4*DIGITS   result digits, packed BCD (registered)
//   cout   out  1          decimal carry out of the top digit (registered)
//   busy   out  1          high while in ADD or DONE
//   done   out  1          one-cycle pulse; sum/cout/err are valid
//   err    out  1          an operand digit was > 9 in the last operation
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                r_state;
  logic [4*DIGITS-1:0]   r_a;
  logic [4*DIGITS-1:0]   r_b;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_carry;
  logic [4*DIGITS-1:0]   r_sum;
  logic                  r_cout;
  logic                  r_err;

  // -------------------------------------------------------------------------
  // Combinational signals
  // -------------------------------------------------------------------------
  state_t                w_next_state;
  logic [3:0]            w_ad;        // current digit of latched A
  logic [3:0]            w_bd;        // current digit of latched B
  logic [4:0]            w_s;         // raw binary digit sum, 0..31
  logic [4:0]            w_s_adj;     // w_s - 10, used when w_s >= 10
  logic                  w_ge10;      // decimal carry out of this digit
  logic [3:0]            w_digit;     // corrected BCD digit
  logic                  w_bad;       // this step sees a non-BCD digit
  logic                  w_last;      // this step handles the top digit
  logic                  w_accept;    // start accepted this cycle

  // -------------------------------------------------------------------------
  // Single-digit BCD adder stage, shared across all digit positions.
  // The digit index selects a nibble of the latched operands; {idx,2'b00}
  // is simply 4*idx without widening the index arithmetic.
  // -------------------------------------------------------------------------
  assign w_ad    = r_a[{r_idx, 2'b00} +: 4];
  assign w_bd    = r_b[{r_idx, 2'b00} +: 4];
  assign w_s     = {1'b0, w_ad} + {1'b0, w_bd} + {4'd0, r_carry};
  assign w_ge10  = (w_s >= 5'd10);
  assign w_s_adj = w_s - 5'd10;
  // Non-BCD operands can push w_s past 19; only the low nibble is kept,
  // and the result is discarded at the end via the error path anyway.
  assign w_digit = w_ge10 ? w_s_adj[3:0] : w_s[3:0];
  assign w_bad   = (w_ad > 4'd9) || (w_bd > 4'd9);
  assign w_last  = (r_idx == IDX_W'(DIGITS - 1));

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_accept     = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = S_ADD;
        end
      end

      S_ADD: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end

      S_DONE: begin
        // Exactly one cycle; any start seen here is dropped, not queued.
        w_next_state = S_IDLE;
      end

      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // in the design samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the latched operands are reset along with everything else;
      // they are plain flops, not a memory, so clearing them is free and
      // keeps post-reset behaviour fully deterministic.
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
          end
        end

        S_ADD: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_digit;
          r_carry                    <= w_ge10;
          if (w_bad) begin
            r_err <= 1'b1;
          end
          if (w_last) begin
            // Leaving ADD: publish the carry, or blank the whole result if
            // any digit (including this last one) was not valid BCD. The
            // later assignment to r_sum overrides the digit write above.
            if (r_err || w_bad) begin
              r_sum  <= '0;
              r_cout <= 1'b0;
            end else begin
              r_cout <= w_ge10;
            end
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end

        S_DONE: begin
          // Results are already in place and simply held from here on.
        end

        default: begin
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign sum  = r_sum;
  assign cout = r_cout;
  assign err  = r_err;
  assign busy = (r_state == S_ADD) || (r_state == S_DONE);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
//
// Self-checking bench for bcd_serial_add_ctrl (DIGITS = 4). The reference
// model works on decimal integers: operands are converted to numbers, added,
// and converted back. A scoreboard process tracks when operations are
// accepted and when done is due, and a compare process checks busy/done on
// every cycle and sum/cout/err whenever they are defined to be stable.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;

  logic              clk;
  logic              rst;
  logic              start;
  logic [4*D-1:0]    a;
  logic [4*D-1:0]    b;
  logic [4*D-1:0]    sum;
  logic              cout;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Comparison helper
  // -------------------------------------------------------------------------
  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Decimal reference: returns {err, cout, sum}
  // -------------------------------------------------------------------------
  function automatic logic [4*D+1:0] bcd_model(input logic [4*D-1:0] x,
                                               input logic [4*D-1:0] y);
    longint vx = 0;
    longint vy = 0;
    longint tot;
    longint scale = 1;
    logic   bad = 1'b0;
    logic [4*D-1:0] s = '0;
    for (int i = 0; i < D; i++) begin
      if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) bad = 1'b1;
      vx += longint'(x[4*i +: 4]) * scale;
      vy += longint'(y[4*i +: 4]) * scale;
      scale *= 10;
    end
    if (bad) return {1'b1, 1'b0, {(4*D){1'b0}}};
    tot = vx + vy;
    for (int i = 0; i < D; i++) begin
      s[4*i +: 4] = 4'(tot % 10);
      tot = tot / 10;
    end
    return {1'b0, (tot != 0), s};
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard: edge counter, accepted-operation tracking, held results
  // -------------------------------------------------------------------------
  int             p      = 0;     // index of the upcoming rising edge
  logic           m_act  = 1'b0;  // an operation has been accepted
  int             m_acc  = 0;     // edge index at which it was accepted
  logic [4*D-1:0] e_sum  = '0;
  logic           e_cout = 1'b0;
  logic           e_err  = 1'b0;
  logic [4*D-1:0] h_sum  = '0;    // value sum must hold when stable
  logic           h_cout = 1'b0;
  logic           h_err  = 1'b0;
  logic           chk_en = 1'b0;

  always @(posedge clk) begin
    p <= p + 1;
    if (rst) begin
      m_act  <= 1'b0;
      h_sum  <= '0;
      h_cout <= 1'b0;
      h_err  <= 1'b0;
    end else if (start && (!m_act || p >= m_acc + D + 2)) begin
      m_act <= 1'b1;
      m_acc <= p;
      {e_err, e_cout, e_sum} <= bcd_model(a, b);
      h_sum  <= '0;
      h_cout <= 1'b0;
      h_err  <= 1'b0;
    end else if (m_act && p == m_acc + D) begin
      h_sum  <= e_sum;
      h_cout <= e_cout;
      h_err  <= e_err;
    end
  end

  // Compare process: p-1 is the index of the edge that just occurred.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", busy, m_act && (p - 1 >= m_acc) && (p - 1 <= m_acc + D));
      check("done", done, m_act && (p - 1 == m_acc + D));
      if (!(m_act && (p - 1 >= m_acc) && (p - 1 < m_acc + D))) begin
        check("sum",  sum,  h_sum);
        check("cout", cout, h_cout);
        check("err",  err,  h_err);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver: one operation. mode 0: single start pulse; 1: random start
  // noise while busy; 2: start held high through ADD and DONE.
  // Returns at the negedge where done is observed.
  // -------------------------------------------------------------------------
  task automatic op(input logic [4*D-1:0] xa, input logic [4*D-1:0] xb,
                    input int mode, output logic [4*D-1:0] s,
                    output logic c, output logic e, output int lat);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(negedge clk);
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      start = (mode == 2) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      @(negedge clk);
      lat++;
    end
    check("done seen", done, 1'b1);
    start = (mode == 2) ? 1'b1 : 1'b0;
    s = sum;
    c = cout;
    e = err;
  endtask

  function automatic logic [4*D-1:0] rand_bcd(input logic bad_ok);
    logic [4*D-1:0] v;
    if ($urandom_range(0, 7) == 0) return {D{4'h9}};
    for (int i = 0; i < D; i++) begin
      if (bad_ok && $urandom_range(0, 15) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else                                      v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    logic [4*D-1:0] s;
    logic           c;
    logic           e;
    int             lat;
    int             ndone;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;

    // Pin the model to hand-computed results.
    check("model 1234+5678", bcd_model(16'h1234, 16'h5678), {2'b00, 16'h6912});
    check("model 9999+0001", bcd_model(16'h9999, 16'h0001), {2'b01, 16'h0000});
    check("model 4999+5001", bcd_model(16'h4999, 16'h5001), {2'b01, 16'h0000});
    check("model 12A4+0001", bcd_model(16'h12A4, 16'h0001), {2'b10, 16'h0000});

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset sum",  sum,  16'h0000);
    check("reset cout", cout, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset err",  err,  1'b0);
    rst = 1'b0;

    // 1) basic add with latency
    op(16'h1234, 16'h5678, 0, s, c, e, lat);
    check("t1 sum", s, 16'h6912);
    check("t1 cout", c, 1'b0);
    check("t1 err", e, 1'b0);
    check("t1 latency", lat, 5);

    // 2) full carry ripple
    op(16'h9999, 16'h0001, 0, s, c, e, lat);
    check("t2 sum", s, 16'h0000);
    check("t2 cout", c, 1'b1);

    // 3) back-to-back
    op(16'h0000, 16'h0000, 0, s, c, e, lat);
    check("t3a sum", s, 16'h0000);
    check("t3a cout", c, 1'b0);
    op(16'h4999, 16'h5001, 0, s, c, e, lat);
    check("t3b sum", s, 16'h0000);
    check("t3b cout", c, 1'b1);
    check("t3b latency", lat, 5);

    // 4) invalid digit, then recovery
    op(16'h12A4, 16'h0001, 0, s, c, e, lat);
    check("t4a err", e, 1'b1);
    check("t4a sum", s, 16'h0000);
    check("t4a cout", c, 1'b0);
    op(16'h0005, 16'h0004, 0, s, c, e, lat);
    check("t4b err", e, 1'b0);
    check("t4b sum", s, 16'h0009);

    // 5) start held through ADD and DONE: one operation only
    op(16'h0500, 16'h0500, 2, s, c, e, lat);
    check("t5 sum", s, 16'h1000);
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("t5 extra done", ndone, 0);
    check("t5 sum held", sum, 16'h1000);

    // 6) reset two cycles into ADD
    @(negedge clk);
    a = 16'h0999;
    b = 16'h0999;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 rst busy", busy, 1'b0);
    check("t6 rst done", done, 1'b0);
    check("t6 rst sum",  sum,  16'h0000);
    check("t6 rst cout", cout, 1'b0);
    check("t6 rst err",  err,  1'b0);
    ndone = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("t6 no done", ndone, 0);
    op(16'h0019, 16'h0019, 0, s, c, e, lat);
    check("t6 sum", s, 16'h0038);

    // Randomised operations with gaps and start noise
    for (int n = 0; n < 60; n++) begin
      logic [4*D-1:0] ra;
      logic [4*D-1:0] rb;
      logic [4*D+1:0] ex;
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(negedge clk);
        start = 1'b0;
      end
      ra = rand_bcd(1'b1);
      rb = rand_bcd(1'b1);
      ex = bcd_model(ra, rb);
      op(ra, rb, ($urandom_range(0, 3) == 0) ? 1 : 0, s, c, e, lat);
      check("rnd result", {e, c, s}, ex);
      check("rnd latency", lat, 5);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
